// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg -- ASCII constants, byte-FSM states and hex decode.  Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_TAB = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Returns {is_hex, nibble}; nibble is zero when is_hex is clear.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [3:0] nib;
    nib = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) nib = 4'(c - 8'h30);
    else if (c >= 8'h41 && c <= 8'h46) nib = 4'(c - 8'h37);
    else if (c >= 8'h61 && c <= 8'h66) nib = 4'(c - 8'h57);
    else return 5'h00;
    return {1'b1, nib};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_byte_rx -- rx synchroniser, oversample tick generator, byte FSM.  Rev 1.0
// ----------------------------------------------------------------------------
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int DVSR     = 163,
  parameter int DVSR_BIT = 8,
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_i,
  output logic [DBIT-1:0] byte_o,
  output logic            byte_strobe_o,
  output logic            frame_err_o
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DVSR_BIT-1:0] tick_cnt_q, tick_cnt_d;
  logic                tick;
  rx_state_e           state_q;
  logic [SW-1:0]       s_q;
  logic [NW-1:0]       n_q;
  logic [DBIT-1:0]     b_q;
  logic [DBIT:0]       w_shift;
  logic                w_last_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign tick       = (tick_cnt_q == DVSR_BIT'(DVSR - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  assign w_shift = {rx_sync_q, b_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (rx_prev_q && !rx_sync_q) begin
            state_q <= ST_START;
            s_q     <= '0;
          end
        ST_START:
          if (tick) begin
            // Mid start bit: a line already back high was only a glitch.
            if (s_q == SW'(7)) begin
              if (!rx_sync_q) begin
                state_q <= ST_DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        ST_DATA:
          if (tick) begin
            if (s_q == SW'(15)) begin
              s_q <= '0;
              b_q <= w_shift[DBIT:1];
              if (n_q == NW'(DBIT - 1)) state_q <= ST_STOP;
              else                      n_q     <= n_q + 1'b1;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        ST_STOP:
          if (tick) begin
            if (s_q == SW'(SB_TICK - 1)) begin
              state_q <= ST_IDLE;
              s_q     <= '0;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes are decoded in the final stop tick so the byte lands in that same clock.
  assign w_last_stop   = (state_q == ST_STOP) && tick && (s_q == SW'(SB_TICK - 1));
  assign byte_strobe_o = w_last_stop && rx_sync_q;
  assign frame_err_o   = w_last_stop && !rx_sync_q;
  assign byte_o        = b_q;

endmodule
`default_nettype wire

// File: rtl/uart_hex_word_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_hex_word_rx -- UART hex-digit stream to W-bit words on valid/ready.  Rev 1.0
// ----------------------------------------------------------------------------
module uart_hex_word_rx
  import uart_pkg::*;
#(
  parameter  int DVSR     = 163,
  parameter  int DVSR_BIT = 8,
  parameter  int DBIT     = 8,
  parameter  int SB_TICK  = 16,
  parameter  int NDIGIT   = 8,
  localparam int W        = 4 * NDIGIT,
  localparam int CW       = $clog2(NDIGIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] digit_cnt,
  output logic          bad_char,
  output logic          frame_err,
  output logic          overrun
);

  logic [DBIT-1:0] rx_byte;
  logic            byte_strobe, byte_ferr;

  uart_byte_rx #(
    .DVSR     (DVSR),
    .DVSR_BIT (DVSR_BIT),
    .DBIT     (DBIT),
    .SB_TICK  (SB_TICK)
  ) u_byte_rx (
    .clk           (clk),
    .reset         (reset),
    .rx_i          (rx),
    .byte_o        (rx_byte),
    .byte_strobe_o (byte_strobe),
    .frame_err_o   (byte_ferr)
  );

  logic [7:0]    w_char;
  logic [4:0]    w_dec;
  logic          w_is_space, w_digit, w_reject, w_complete, w_xfer;
  logic [W-1:0]  w_next;
  logic [W-1:0]  acc_q, out_data_q;
  logic [CW-1:0] digit_cnt_q;
  logic          out_valid_q, bad_char_q, frame_err_q, overrun_q;

  assign w_char     = 8'(rx_byte);
  assign w_dec      = hex_decode(w_char);
  assign w_is_space = (w_char == ASCII_SP) || (w_char == ASCII_TAB) ||
                      (w_char == ASCII_LF) || (w_char == ASCII_CR);
  assign w_digit    = byte_strobe && w_dec[4];
  assign w_reject   = byte_ferr || (byte_strobe && !w_dec[4]);
  assign w_complete = w_digit && (digit_cnt_q == CW'(NDIGIT - 1));
  assign w_next     = W'({acc_q, w_dec[3:0]});
  assign w_xfer     = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      digit_cnt_q <= '0;
      bad_char_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bad_char_q  <= byte_strobe && !w_dec[4] && !w_is_space;
      frame_err_q <= byte_ferr;
      if (w_reject || w_complete) begin
        acc_q       <= '0;
        digit_cnt_q <= '0;
      end else if (w_digit) begin
        acc_q       <= w_next;
        digit_cnt_q <= digit_cnt_q + 1'b1;
      end
    end
  end

  // A word may load into a slot that is being drained in the same clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (w_complete) begin
        if (!out_valid_q || w_xfer) begin
          out_data_q  <= w_next;
          out_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (w_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign digit_cnt = digit_cnt_q;
  assign bad_char  = bad_char_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_word_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_hex_word_rx -- scenario tasks plus randomized streams vs a string-level model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_hex_word_rx;

  localparam int DVSR     = 4;
  localparam int DVSR_BIT = 3;
  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int NDIGIT   = 8;
  localparam int W        = 4 * NDIGIT;
  localparam int CW       = $clog2(NDIGIT + 1);
  localparam int BIT_CLKS = 16 * DVSR;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [CW-1:0] digit_cnt;
  logic          bad_char, frame_err, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] got_q[$];
  int n_bad = 0, n_ferr = 0, n_ovr = 0, n_vhigh = 0;

  always #5 clk = ~clk;

  uart_hex_word_rx #(
    .DVSR     (DVSR),
    .DVSR_BIT (DVSR_BIT),
    .DBIT     (DBIT),
    .SB_TICK  (SB_TICK),
    .NDIGIT   (NDIGIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit_cnt (digit_cnt),
    .bad_char  (bad_char),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (out_valid) n_vhigh++;
      if (bad_char)  n_bad++;
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_ok);
    if (!stop_ok) hold_bit(1'b1);
    rx = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  // Position of c in the hex alphabet (case-insensitive), -1 if absent.
  function automatic int hex_value(input logic [7:0] c);
    string digits;
    logic [7:0] u;
    digits = "0123456789ABCDEF";
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    for (int i = 0; i < 16; i++) if (digits[i] == u) return i;
    return -1;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_data, out_valid, digit_cnt, bad_char, frame_err, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h valid=%b cnt=%0d bad=%b ferr=%b ovr=%b want all zero",
               out_data, out_valid, digit_cnt, bad_char, frame_err, overrun);
    end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || digit_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b cnt=%0d want 0/0", out_valid, digit_cnt);
    end
  endtask

  task automatic test_basic();
    int base, v0;
    set_ready(1'b1);
    base = got_q.size();
    v0 = n_vhigh;
    send_str("1234ABCD");
    n_tests++;
    if (got_q.size() - base != 1) begin
      n_fail++;
      $display("FAIL basic_count: got %0d words want 1", got_q.size() - base);
    end else begin
      n_tests++;
      if (got_q[base] !== 32'h1234ABCD) begin
        n_fail++;
        $display("FAIL basic_word: got %h want 1234abcd", got_q[base]);
      end
    end
    n_tests++;
    if (n_vhigh - v0 != 1) begin
      n_fail++;
      $display("FAIL basic_valid_pulse: valid high %0d clks want 1", n_vhigh - v0);
    end
    n_tests++;
    if (digit_cnt !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: cnt=%0d valid=%b want 0/0", digit_cnt, out_valid);
    end
  endtask

  task automatic test_overrun();
    int base, o0;
    set_ready(1'b0);
    base = got_q.size();
    o0 = n_ovr;
    send_str("deadBEEF");
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL ovr_hold: valid=%b data=%h want 1/deadbeef", out_valid, out_data);
    end
    send_str("00000001");
    n_tests++;
    if (n_ovr - o0 != 1) begin
      n_fail++;
      $display("FAIL ovr_pulse: overrun high %0d clks want 1", n_ovr - o0);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || got_q.size() != base) begin
      n_fail++;
      $display("FAIL ovr_kept: valid=%b data=%h xfers=%0d want 1/deadbeef/0",
               out_valid, out_data, got_q.size() - base);
    end
    set_ready(1'b1);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || got_q.size() - base != 1) begin
      n_fail++;
      $display("FAIL ovr_drain: valid=%b xfers=%0d want 0/1", out_valid, got_q.size() - base);
    end else begin
      n_tests++;
      if (got_q[base] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL ovr_drain_word: got %h want deadbeef", got_q[base]);
      end
    end
  endtask

  task automatic test_whitespace();
    int base, b0;
    base = got_q.size();
    b0 = n_bad;
    send_str("12");
    n_tests++;
    if (digit_cnt !== CW'(2)) begin
      n_fail++;
      $display("FAIL ws_partial: cnt=%0d want 2", digit_cnt);
    end
    send_byte(8'h0A, 1'b1);
    n_tests++;
    if (digit_cnt !== '0 || got_q.size() != base || n_bad != b0) begin
      n_fail++;
      $display("FAIL ws_discard: cnt=%0d words=%0d bad=%0d want 0/0/0",
               digit_cnt, got_q.size() - base, n_bad - b0);
    end
    send_str("89ABCDEF");
    n_tests++;
    if (got_q.size() - base != 1) begin
      n_fail++;
      $display("FAIL ws_count: got %0d words want 1", got_q.size() - base);
    end else begin
      n_tests++;
      if (got_q[base] !== 32'h89ABCDEF) begin
        n_fail++;
        $display("FAIL ws_word: got %h want 89abcdef", got_q[base]);
      end
    end
  endtask

  task automatic test_bad_char();
    int b0;
    b0 = n_bad;
    send_str("12G");
    n_tests++;
    if (n_bad - b0 != 1 || digit_cnt !== '0) begin
      n_fail++;
      $display("FAIL bad_pulse: bad high %0d clks cnt=%0d want 1/0", n_bad - b0, digit_cnt);
    end
    send_str("3");
    n_tests++;
    if (digit_cnt !== CW'(1)) begin
      n_fail++;
      $display("FAIL bad_resume: cnt=%0d want 1", digit_cnt);
    end
    send_str(" ");
    n_tests++;
    if (digit_cnt !== '0 || n_bad - b0 != 1) begin
      n_fail++;
      $display("FAIL bad_space: cnt=%0d bad=%0d want 0/1", digit_cnt, n_bad - b0);
    end
  endtask

  task automatic test_frame_err();
    int f0, b0, base;
    f0 = n_ferr;
    b0 = n_bad;
    base = got_q.size();
    send_byte("5", 1'b0);
    n_tests++;
    if (n_ferr - f0 != 1 || digit_cnt !== '0 || n_bad != b0) begin
      n_fail++;
      $display("FAIL ferr_pulse: ferr=%0d cnt=%0d bad=%0d want 1/0/0",
               n_ferr - f0, digit_cnt, n_bad - b0);
    end
    send_str("7");
    send_byte("5", 1'b0);
    n_tests++;
    if (n_ferr - f0 != 2 || digit_cnt !== '0) begin
      n_fail++;
      $display("FAIL ferr_discard: ferr=%0d cnt=%0d want 2/0", n_ferr - f0, digit_cnt);
    end
    send_str("5 ");
    n_tests++;
    if (n_ferr - f0 != 2 || got_q.size() != base || digit_cnt !== '0) begin
      n_fail++;
      $display("FAIL ferr_recover: ferr=%0d words=%0d cnt=%0d want 2/0/0",
               n_ferr - f0, got_q.size() - base, digit_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [7:0] ch;
    ch = "E";
    send_str("CAF");
    hold_bit(1'b0);
    for (int i = 0; i < 3; i++) hold_bit(ch[i]);
    reset = 1'b1;
    #2;
    n_tests++;
    if ({out_data, out_valid, digit_cnt, bad_char, frame_err, overrun} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: data=%h valid=%b cnt=%0d bad=%b ferr=%b ovr=%b want all zero",
               out_data, out_valid, digit_cnt, bad_char, frame_err, overrun);
    end
    rx = 1'b1;
    repeat (BIT_CLKS) @(posedge clk);
    #1 reset = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    base = got_q.size();
    send_str("CAFEF00D");
    n_tests++;
    if (got_q.size() - base != 1) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d words want 1", got_q.size() - base);
    end else begin
      n_tests++;
      if (got_q[base] !== 32'hCAFEF00D) begin
        n_fail++;
        $display("FAIL midreset_word: got %h want cafef00d", got_q[base]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] stream[$];
    logic [W-1:0] exp_q[$];
    longint val;
    int ndig, exp_bad, base, b0, v;
    string lo, up;
    logic [7:0] spaces[4];
    lo = "0123456789abcdef";
    up = "0123456789ABCDEF";
    spaces = '{8'h20, 8'h09, 8'h0A, 8'h0D};
    for (int w = 0; w < 3; w++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        stream.push_back(lo[$urandom_range(0, 15)]);
      case ($urandom_range(0, 2))
        0:       stream.push_back(spaces[$urandom_range(0, 3)]);
        1:       stream.push_back(8'(8'h47 + $urandom_range(0, 15)));
        default: ;
      endcase
      for (int j = 0; j < NDIGIT; j++)
        stream.push_back($urandom_range(0, 1) ? up[$urandom_range(0, 15)] : lo[$urandom_range(0, 15)]);
    end
    // Reference: words are every NDIGIT consecutive hex digits not broken by another byte.
    ndig = 0;
    val = 0;
    exp_bad = 0;
    foreach (stream[i]) begin
      v = hex_value(stream[i]);
      if (v >= 0) begin
        val = val * 16 + v;
        ndig++;
        if (ndig == NDIGIT) begin
          exp_q.push_back(W'(val));
          ndig = 0;
          val = 0;
        end
      end else begin
        if (!(stream[i] inside {8'h20, 8'h09, 8'h0A, 8'h0D})) exp_bad++;
        ndig = 0;
        val = 0;
      end
    end
    base = got_q.size();
    b0 = n_bad;
    foreach (stream[i]) send_byte(stream[i], 1'b1);
    n_tests++;
    if (got_q.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d words want %0d", got_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_tests++;
        if (got_q[base + k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL rand_word%0d: got %h want %h", k, got_q[base + k], exp_q[k]);
        end
      end
    end
    n_tests++;
    if (n_bad - b0 != exp_bad || digit_cnt !== CW'(ndig)) begin
      n_fail++;
      $display("FAIL rand_state: bad=%0d cnt=%0d want %0d/%0d", n_bad - b0, digit_cnt, exp_bad, ndig);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_whitespace();
    test_bad_char();
    test_frame_err();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_hex_word_rx.md
# uart_hex_word_rx

Parametrised UART receiver that turns a stream of ASCII hex digits into fixed-width words delivered over a valid/ready handshake. It contains baud generation, rx synchronisation, byte reception, hex decoding and word assembly, all on the system clock. It replaces the fixed 8-digit, rx_done-clocked collector in the UART input path and feeds the project's command and data consumers.

## Interface
- DVSR, 163: baud divisor, clk/(16·baud); one oversample tick every DVSR clocks.
- DVSR_BIT, 8: width of the divisor counter; must satisfy 2^DVSR_BIT ≥ DVSR.
- DBIT, 8: data bits per frame.
- SB_TICK, 16: oversample ticks per stop period (16/24/32 for 1/1.5/2 stop bits).
- NDIGIT, 8: hex digits per word, 1..16. Derived W = 4·NDIGIT.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- rx  in  1  serial line, idle high, asynchronous to clk.
- out_data  out  W  assembled word; first received digit in the MS nibble.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- digit_cnt  out  $clog2(NDIGIT+1)  digits held in the accumulator.
- bad_char  out  1  one-clk pulse: non-hex, non-whitespace byte received.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- overrun  out  1  one-clk pulse: completed word dropped because out_valid was already set.

## Operation
- rx passes through a 2-FF synchroniser (reset value 1) before use.
- Tick generator: counts 0..DVSR-1 and pulses tick at DVSR-1. It runs freely after reset.
- Byte FSM:
  - IDLE: falling edge → START, with the tick counter s cleared.
  - START: at s==7, if rx is still low → DATA with s=0 and n=0; otherwise → IDLE (glitch rejected).
  - DATA: at s==15, shift rx into the byte LSB-first. After DBIT bits → STOP.
  - STOP: at s==SB_TICK-1, issue the byte strobe (rx high) or frame_err (rx low), then → IDLE.
- Decode: '0'-'9', 'A'-'F' and 'a'-'f' map to 0x0–0xF.
  - Whitespace (0x20, 0x09, 0x0A, 0x0D) discards the partial word silently; digit_cnt → 0.
  - Any other byte discards the partial word and pulses bad_char.
  - A frame error discards the partial word; the byte is not decoded.
- Accumulator: acc ← {acc[W-5:0], nibble}, digit_cnt+1. When digit_cnt reaches NDIGIT, the word completes and the accumulator clears to count 0. No terminator is required.
- Output register:
  - A completed word loads out_data and sets out_valid when out_valid==0 or a transfer occurs in the same cycle.
  - Otherwise the new word is dropped, overrun pulses, and out_data is unchanged.
  - A transfer with no completion clears out_valid; out_data holds its last value.
- Reset values: out_data 0, out_valid 0, digit_cnt 0, all pulses 0, FSM IDLE, counters 0, synchroniser 1.
- Reset asserted mid-frame aborts the frame and loses the partial word. After release the block waits for a fresh falling edge.

## Timing
- The byte strobe fires in the clk of the final stop-bit tick.
- Accumulator and digit_cnt update on the next edge (latency 1).
- out_valid rises on the same edge as the completing accumulator update.
- bad_char and frame_err are asserted 1 clk after their causing strobe or tick, for exactly 1 clk. overrun is asserted in the clk out_valid would have loaded.
- out_ready has no combinational path to out_valid or out_data. Back-to-back words are accepted every frame while out_ready stays high.
- Byte throughput is bounded by the line rate. Decode never stalls the FSM.

## Structure
- Package uart_pkg holds: ASCII constants (CR, LF, SP, TAB), the byte-FSM state enum, and a hex_decode function returning {is_hex, nibble}.
- Sub-module uart_byte_rx contains the synchroniser, tick generator and byte FSM. It outputs byte, byte_strobe and frame_err.
- The top level holds the decode, accumulator and output register.

## Test plan
All scenarios use DVSR=4, DBIT=8, SB_TICK=16, NDIGIT=8.
- Send "1234ABCD" with out_ready=1 → a single out_valid pulse, out_data=0x1234ABCD, digit_cnt back to 0.
- Send "deadBEEF" with out_ready=0, then hold → out_data=0xDEADBEEF with out_valid held. Send "00000001" → overrun pulses once and out_data stays 0xDEADBEEF. Raise out_ready → one transfer, out_valid=0.
- Send "12\n89ABCDEF" → no word after "12\n", digit_cnt=0 after LF, then out_data=0x89ABCDEF.
- Send "12G3" → bad_char pulses once at 'G', digit_cnt=0, then 1 after '3'.
- Send '5' with a low stop bit → frame_err pulses, digit_cnt unchanged at 0, no byte strobe.
- Assert reset during the data bits of the 4th digit, release, then send "CAFEF00D" → out_data=0xCAFEF00D and all outputs were at reset values during reset.
